// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI bus configuration and default request/response struct types
package obi_pkg;

    typedef struct packed {
        logic        UseRReady;
        logic        UseAtop;
        logic        Integrity;
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        UseRReady: 1'b0,
        UseAtop:   1'b0,
        Integrity: 1'b0,
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

endpackage

// File: rtl/obi_seq_mgr.sv
// rtl/obi_seq_mgr.sv - OBI manager issuing pattern write / read-check runs
// Optional random request/rready stalls: define OBI_SEQ_MGR_RANDOM_STALL_EN.
module obi_seq_mgr #(
    parameter obi_pkg::obi_cfg_t ObiCfg         = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t      = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t      = obi_pkg::obi_rsp_t,
    parameter int unsigned       MaxOutstanding = 4,
    parameter int unsigned       CntWidth       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        we_i,
    input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
    input  logic [CntWidth-1:0]         num_words_i,
    input  logic [ObiCfg.DataWidth-1:0] seed_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CntWidth-1:0]         err_cnt_o,
    output obi_req_t                    obi_req_o,
    input  obi_rsp_t                    obi_rsp_i
);

    localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
    localparam int unsigned DataWidth = ObiCfg.DataWidth;
    localparam int unsigned OutWidth  = $clog2(MaxOutstanding + 1);
    localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(DataWidth / 8);
    localparam logic [OutWidth-1:0]  MaxOut    = OutWidth'(MaxOutstanding);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 we_q;
    logic [DataWidth-1:0] seed_q;
    logic [AddrWidth-1:0] issue_addr_q, rsp_addr_q;
    logic [CntWidth-1:0]  issue_left_q, err_cnt_q;
    logic [OutWidth-1:0]  out_q;
    logic                 req, rready, gnt_acc, rsp_acc, rsp_tracked, active, start_run;
    logic [1:0]           err_inc;
    logic [CntWidth:0]    err_sum;
    logic [DataWidth-1:0] expected;
    logic                 unused_rsp;

    assign start_run = (state_q == IDLE) && start_i;
    assign active    = (state_q == ISSUE) || (state_q == DRAIN);

`ifdef OBI_SEQ_MGR_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic        hold_q;

    // hold_q keeps a raised but ungranted request up regardless of lfsr[0]
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= '0;
            hold_q <= 1'b0;
        end else begin
            if (start_run) lfsr_q <= seed_i[15:0] | 16'h0001;
            else           lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            hold_q <= req && !obi_rsp_i.gnt;
        end
    end

    assign req    = (state_q == ISSUE) && (hold_q || ((out_q < MaxOut) && lfsr_q[0]));
    assign rready = ObiCfg.UseRReady && active && lfsr_q[1];
`else
    assign req    = (state_q == ISSUE) && (out_q < MaxOut);
    assign rready = ObiCfg.UseRReady && active;
`endif

    assign gnt_acc     = req && obi_rsp_i.gnt;
    assign rsp_acc     = obi_rsp_i.rvalid && (rready || !ObiCfg.UseRReady);
    assign rsp_tracked = rsp_acc && active && (out_q != '0);
    assign expected    = DataWidth'(rsp_addr_q) ^ seed_q;
    assign unused_rsp  = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    // Responses seen outside a run (stray rvalid in IDLE) are not counted
    always_comb begin
        err_inc = 2'd0;
        if (rsp_acc && active) begin
            if (out_q == '0) err_inc = 2'd1;
            else             err_inc = {1'b0, obi_rsp_i.r.err}
                                     + {1'b0, (!we_q && (obi_rsp_i.r.rdata != expected))};
        end
        err_sum = {1'b0, err_cnt_q} + (CntWidth+1)'(err_inc);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (num_words_i == '0) ? DONE : ISSUE;
            ISSUE:   if (gnt_acc && (issue_left_q == CntWidth'(1))) state_d = DRAIN;
            DRAIN:   if (out_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            seed_q       <= '0;
            issue_addr_q <= '0;
            rsp_addr_q   <= '0;
            issue_left_q <= '0;
            out_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                we_q         <= we_i;
                seed_q       <= seed_i;
                issue_addr_q <= base_addr_i;
                rsp_addr_q   <= base_addr_i;
                issue_left_q <= num_words_i;
                err_cnt_q    <= '0;
            end else begin
                if (gnt_acc) begin
                    issue_addr_q <= issue_addr_q + WordBytes;
                    issue_left_q <= issue_left_q - CntWidth'(1);
                end
                if (rsp_tracked) rsp_addr_q <= rsp_addr_q + WordBytes;
                if (gnt_acc != rsp_tracked)
                    out_q <= gnt_acc ? out_q + OutWidth'(1) : out_q - OutWidth'(1);
                err_cnt_q <= err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
            end
        end
    end

    // A-channel is zero whenever req is low; while req is high it is purely registered state
    always_comb begin
        obi_req_o        = '0;
        obi_req_o.req    = req;
        obi_req_o.rready = rready;
        if (req) begin
            obi_req_o.a.addr  = issue_addr_q;
            obi_req_o.a.we    = we_q;
            obi_req_o.a.be    = '1;
            obi_req_o.a.wdata = we_q ? (DataWidth'(issue_addr_q) ^ seed_q) : '0;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_obi_seq_mgr.sv
// tb/tb_obi_seq_mgr.sv - self-checking bench for obi_seq_mgr with a scoreboarded memory subordinate
module tb_obi_seq_mgr;

    localparam int MaxOut = 4;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, we = 1'b0;
    logic [31:0] base_addr = '0, seed = '0;
    logic [15:0] num_words = '0;
    logic        busy, done;
    logic [15:0] err_cnt;
    obi_pkg::obi_req_t obi_req;
    obi_pkg::obi_rsp_t obi_rsp = '0;

    always #5 clk = ~clk;

    obi_seq_mgr #(.MaxOutstanding(MaxOut), .CntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .we_i(we),
        .base_addr_i(base_addr), .num_words_i(num_words), .seed_i(seed),
        .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt),
        .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } exp_t;
    typedef struct { logic [31:0] rdata; logic err; int due; } rsp_t;

    exp_t        sb[$];
    rsp_t        pend[$];
    logic [31:0] mem [logic [31:0]];

    int checks = 0, passed = 0;
    int cyc = 0, granted = 0, accepted = 0, cur_out = 0, max_out = 0;
    int done_pulses = 0, req_cycles = 0, stall_seen = 0, stall_bad = 0;
    int stall_word = -1, stall_len = 0, rsp_delay = 0, err_word = -1;
    logic [31:0] stall_addr, stall_wdata;

    // Subordinate + scoreboard: decides gnt/rvalid for the coming edge on each falling edge
    always @(negedge clk) begin
        exp_t e;
        rsp_t r;
        cyc++;
        obi_rsp.rvalid = 1'b0;
        obi_rsp.r      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            obi_rsp.rvalid  = 1'b1;
            obi_rsp.r.rdata = pend[0].rdata;
            obi_rsp.r.err   = pend[0].err;
            void'(pend.pop_front());
            accepted++;
            if (cur_out > 0) cur_out--;
        end
        obi_rsp.gnt = 1'b1;
        if (stall_seen > 0 && stall_seen < stall_len && !obi_req.req) stall_bad++;
        if (obi_req.req && granted == stall_word && stall_seen < stall_len) begin
            obi_rsp.gnt = 1'b0;
            if (stall_seen == 0) begin
                stall_addr  = obi_req.a.addr;
                stall_wdata = obi_req.a.wdata;
            end else if (obi_req.a.addr !== stall_addr || obi_req.a.wdata !== stall_wdata) begin
                stall_bad++;
            end
            stall_seen++;
        end
        if (obi_req.req) req_cycles++;
        if (done) done_pulses++;
        if (obi_req.req && obi_rsp.gnt) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_req got addr=%h we=%b none expected", obi_req.a.addr, obi_req.a.we);
            end else begin
                e = sb.pop_front();
                if (obi_req.a.addr !== e.addr || obi_req.a.we !== e.we ||
                    obi_req.a.wdata !== e.wdata || obi_req.a.be !== 4'hf)
                    $display("FAIL sb_req got addr=%h we=%b wdata=%h be=%h exp addr=%h we=%b wdata=%h be=f",
                             obi_req.a.addr, obi_req.a.we, obi_req.a.wdata, obi_req.a.be, e.addr, e.we, e.wdata);
                else passed++;
            end
            if (obi_req.a.we) mem[obi_req.a.addr] = obi_req.a.wdata;
            r.rdata = (!obi_req.a.we && mem.exists(obi_req.a.addr)) ? mem[obi_req.a.addr] : 32'h0;
            r.err   = (granted == err_word);
            r.due   = cyc + 1 + rsp_delay;
            pend.push_back(r);
            granted++;
            cur_out++;
            if (cur_out > max_out) max_out = cur_out;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_stats();
        granted = 0; accepted = 0; max_out = 0; done_pulses = 0;
        req_cycles = 0; stall_seen = 0; stall_bad = 0; cur_out = 0;
    endtask

    // Pushes the expected request stream, pulses start, returns cycles until done (300 = timeout)
    task automatic run(input logic w, input logic [31:0] b, input int n, input logic [31:0] s, output int lat);
        logic [31:0] a;
        a = b;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: a, we: w, wdata: w ? (a ^ s) : 32'h0});
            a = a + 32'd4;
        end
        clear_stats();
        @(negedge clk);
        we = w; base_addr = b; num_words = 16'(n); seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (obi_req !== '0) $display("FAIL reset_req got %h exp 0", obi_req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        checks++; if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt got %h exp 0", err_cnt); else passed++;
    endtask

    task automatic test_write();
        int lat;
        run(1'b1, 32'h1000, 4, 32'hA5A5A5A5, lat);
        checks++; if (lat >= 300) $display("FAIL write_timeout got %0d cycles exp <300", lat); else passed++;
        checks++; if (mem[32'h1004] !== 32'hA5A5B5A1) $display("FAIL write_mem1004 got %h exp a5a5b5a1", mem[32'h1004]); else passed++;
        checks++; if (done_pulses !== 1) $display("FAIL write_done_pulses got %0d exp 1", done_pulses); else passed++;
        checks++; if (err_cnt !== 16'h0) $display("FAIL write_err_cnt got %0d exp 0", err_cnt); else passed++;
        checks++; if (accepted !== 4) $display("FAIL write_responses got %0d exp 4", accepted); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL write_busy_after got %b exp 0", busy); else passed++;
    endtask

    task automatic test_read();
        int lat;
        run(1'b0, 32'h1000, 4, 32'hA5A5A5A5, lat);
        checks++; if (lat >= 300) $display("FAIL read_timeout got %0d cycles exp <300", lat); else passed++;
        checks++; if (accepted !== 4) $display("FAIL read_responses got %0d exp 4", accepted); else passed++;
        checks++; if (err_cnt !== 16'h0) $display("FAIL read_err_cnt got %0d exp 0", err_cnt); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL read_sb_left got %0d exp 0", sb.size()); else passed++;
    endtask

    task automatic test_read_errors();
        int lat;
        mem[32'h1008] = 32'h0;
        err_word = 0;
        run(1'b0, 32'h1000, 4, 32'hA5A5A5A5, lat);
        err_word = -1;
        mem[32'h1008] = 32'h1008 ^ 32'hA5A5A5A5;
        checks++; if (err_cnt !== 16'd2) $display("FAIL rderr_err_cnt got %0d exp 2", err_cnt); else passed++;
        checks++; if (done_pulses !== 1) $display("FAIL rderr_done_pulses got %0d exp 1", done_pulses); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        stall_word = 1; stall_len = 5; rsp_delay = 10;
        run(1'b1, 32'h3000, 8, 32'h12345678, lat);
        stall_word = -1; stall_len = 0; rsp_delay = 0;
        checks++; if (stall_seen !== 5) $display("FAIL stall_cycles got %0d exp 5", stall_seen); else passed++;
        checks++; if (stall_bad !== 0) $display("FAIL stall_stability got %0d unstable cycles exp 0", stall_bad); else passed++;
        checks++; if (max_out !== MaxOut) $display("FAIL stall_max_outstanding got %0d exp %0d", max_out, MaxOut); else passed++;
        checks++; if (err_cnt !== 16'h0) $display("FAIL stall_err_cnt got %0d exp 0", err_cnt); else passed++;
        run(1'b0, 32'h3000, 8, 32'h12345678, lat);
        checks++; if (err_cnt !== 16'h0) $display("FAIL b2b_read_err_cnt got %0d exp 0", err_cnt); else passed++;
        checks++; if (accepted !== 8) $display("FAIL b2b_read_responses got %0d exp 8", accepted); else passed++;
    endtask

    task automatic test_latency();
        int lat;
        run(1'b1, 32'h4000, 1, 32'h0, lat);
        checks++; if (lat !== 4) $display("FAIL latency_one_word got %0d exp 4", lat); else passed++;
    endtask

    task automatic test_zero_and_wrap();
        int lat;
        run(1'b1, 32'h5000, 0, 32'h0, lat);
        checks++; if (lat !== 1) $display("FAIL zero_latency got %0d exp 1", lat); else passed++;
        checks++; if (req_cycles !== 0) $display("FAIL zero_req_cycles got %0d exp 0", req_cycles); else passed++;
        checks++; if (done_pulses !== 1) $display("FAIL zero_done_pulses got %0d exp 1", done_pulses); else passed++;
        run(1'b1, 32'hFFFFFFFC, 2, 32'h0F0F0F0F, lat);
        checks++; if (!mem.exists(32'h0) || mem[32'h0] !== 32'h0F0F0F0F)
            $display("FAIL wrap_mem0 got %h exp 0f0f0f0f", mem.exists(32'h0) ? mem[32'h0] : 32'hx);
        else passed++;
        run(1'b0, 32'hFFFFFFFC, 2, 32'h0F0F0F0F, lat);
        checks++; if (err_cnt !== 16'h0) $display("FAIL wrap_read_err_cnt got %0d exp 0", err_cnt); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int k, lat;
        logic [31:0] a;
        a = 32'h6000;
        rsp_delay = 10;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{addr: a, we: 1'b1, wdata: a ^ 32'h55AA55AA});
            a = a + 32'd4;
        end
        clear_stats();
        @(negedge clk);
        we = 1'b1; base_addr = 32'h6000; num_words = 16'd8; seed = 32'h55AA55AA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (cur_out < 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        checks++; if (k >= 50) $display("FAIL rstmid_reach_outstanding got %0d exp 3", cur_out); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (obi_req !== '0) $display("FAIL rstmid_req got %h exp 0", obi_req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cur_out = 0;
        rsp_delay = 0;
        repeat (20) @(negedge clk);
        checks++; if (pend.size() !== 0) $display("FAIL rstmid_stray_drain got %0d pending exp 0", pend.size()); else passed++;
        checks++; if (err_cnt !== 16'h0) $display("FAIL rstmid_stray_err_cnt got %0d exp 0", err_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_stray_busy got %b exp 0", busy); else passed++;
        run(1'b1, 32'h6000, 4, 32'h55AA55AA, lat);
        checks++; if (done_pulses !== 1) $display("FAIL rstmid_rerun_done got %0d exp 1", done_pulses); else passed++;
        run(1'b0, 32'h6000, 4, 32'h55AA55AA, lat);
        checks++; if (err_cnt !== 16'h0) $display("FAIL rstmid_rerun_err_cnt got %0d exp 0", err_cnt); else passed++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write();
        test_read();
        test_read_errors();
        test_back_to_back();
        test_latency();
        test_zero_and_wrap();
        test_reset_mid_run();
        checks++; if (sb.size() !== 0) $display("FAIL final_sb_left got %0d exp 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
